// File: rtl/vga_pkg.sv
// Shared VGA defaults: 640x480@60 timing, sync polarity constants and the
// colour-bar lookup used by the optional test pattern.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_COLOR_W  = 8;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef enum logic [1:0] {
        REGION_ACTIVE,
        REGION_FRONT,
        REGION_SYNC,
        REGION_BACK
    } axis_region_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } bar_rgb_t;

    localparam int unsigned BAR_COUNT = 8;

    // Entry i holds {R,G,B} for bar i.
    localparam logic [3*BAR_COUNT-1:0] BAR_RGB_LUT = {
        3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000
    };

    function automatic bar_rgb_t bar_color(input logic [2:0] idx);
        return BAR_RGB_LUT[3*idx +: 3];
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter with wrap strobe
// and active/sync region decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK,
    parameter int unsigned W      = $clog2(ACTIVE + FRONT + SYNC + BACK)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
    localparam logic [W-1:0] FRONT_START = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START  = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] BACK_START  = W'(ACTIVE + FRONT + SYNC);

    logic [W-1:0] count_q, count_d;
    axis_region_e region;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        region = REGION_BACK;
        if (count_q < FRONT_START) begin
            region = REGION_ACTIVE;
        end else if (count_q < SYNC_START) begin
            region = REGION_FRONT;
        end else if (count_q < BACK_START) begin
            region = REGION_SYNC;
        end
    end

    assign count_o  = count_q;
    assign wrap_o   = inc_i && !clr_i && (count_q == LAST);
    assign active_o = (region == REGION_ACTIVE);
    assign sync_o   = (region == REGION_SYNC);

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator with registered, blanked colour output.
// Optional macro TEST_PATTERN_EN adds an internal 8-bar colour test pattern.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter logic        H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic        V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned COLOR_W    = DEF_COLOR_W,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned X_W       = $clog2(H_TOTAL),
    localparam int unsigned Y_W       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               enable,
    input  logic [COLOR_W-1:0] inRed,
    input  logic [COLOR_W-1:0] inGreen,
    input  logic [COLOR_W-1:0] inBlue,
    input  logic               testMode,
    output logic [X_W-1:0]     pixelX,
    output logic [Y_W-1:0]     pixelY,
    output logic               pixelValid,
    output logic               pixTick,
    output logic               hSync,
    output logic               vSync,
    output logic               videoOn,
    output logic               frameStart,
    output logic               lineStart,
    output logic [COLOR_W-1:0] outRed,
    output logic [COLOR_W-1:0] outGreen,
    output logic [COLOR_W-1:0] outBlue
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    logic [X_W-1:0] h_count;
    logic [Y_W-1:0] v_count;
    logic           h_wrap, h_active, h_sync;
    logic           v_wrap_unused, v_active, v_sync;

    logic [COLOR_W-1:0] src_r, src_g, src_b;

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_q, video_d;
    logic               frame_q, frame_d;
    logic               line_q, line_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    // The tick is registered from the next divider value so that it is low
    // during reset even when CLK_DIV=1, and still high exactly while the
    // divider sits at CLK_DIV-1.
    always_comb begin
        div_d = '0;
        if (enable && (div_q != DIV_LAST)) begin
            div_d = div_q + DIV_W'(1);
        end
        tick_d = enable && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign pixTick = tick_q && enable;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .W      (X_W)
    ) u_h_counter (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .clr_i    (!enable),
        .inc_i    (pixTick),
        .count_o  (h_count),
        .wrap_o   (h_wrap),
        .active_o (h_active),
        .sync_o   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .W      (Y_W)
    ) u_v_counter (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .clr_i    (!enable),
        .inc_i    (h_wrap),
        .count_o  (v_count),
        .wrap_o   (v_wrap_unused),
        .active_o (v_active),
        .sync_o   (v_sync)
    );

    assign pixelX     = h_count;
    assign pixelY     = v_count;
    assign pixelValid = h_active && v_active;

`ifdef TEST_PATTERN_EN
    localparam int unsigned SCALE_W = X_W + 3;

    logic [SCALE_W-1:0] bar_scaled;
    logic [2:0]         bar_idx;
    bar_rgb_t           bar;

    assign bar_scaled = {h_count, 3'b000} / SCALE_W'(H_ACTIVE);
    assign bar_idx    = 3'(bar_scaled);
    assign bar        = bar_color(bar_idx);
    assign src_r      = testMode ? {COLOR_W{bar.r}} : inRed;
    assign src_g      = testMode ? {COLOR_W{bar.g}} : inGreen;
    assign src_b      = testMode ? {COLOR_W{bar.b}} : inBlue;
`else
    logic unused_test_mode;

    assign unused_test_mode = testMode;
    assign src_r            = inRed;
    assign src_g            = inGreen;
    assign src_b            = inBlue;
`endif

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        video_d = video_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        frame_d = 1'b0;
        line_d  = 1'b0;
        if (!enable) begin
            hsync_d = ~H_SYNC_POL;
            vsync_d = ~V_SYNC_POL;
            video_d = 1'b0;
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end else if (pixTick) begin
            hsync_d = h_sync ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_d = v_sync ? V_SYNC_POL : ~V_SYNC_POL;
            video_d = pixelValid;
            red_d   = pixelValid ? src_r : '0;
            green_d = pixelValid ? src_g : '0;
            blue_d  = pixelValid ? src_b : '0;
            frame_d = (h_count == '0) && (v_count == '0);
            line_d  = (h_count == '0) && v_active;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            video_q <= 1'b0;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign videoOn    = video_q;
    assign frameStart = frame_q;
    assign lineStart  = line_q;
    assign outRed     = red_q;
    assign outGreen   = green_q;
    assign outBlue    = blue_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Scoreboard bench for vga_timing_core on a small 8x6 timing with CLK_DIV=2.
module tb_vga_timing_core;

    logic       clk;
    logic       rstN;
    logic       enable;
    logic       testMode;
    logic [7:0] inRed, inGreen, inBlue;
    logic [2:0] pixelX, pixelY;
    logic       pixelValid, pixTick, hSync, vSync, videoOn, frameStart, lineStart;
    logic [7:0] outRed, outGreen, outBlue;

    typedef struct packed {
        logic       tick;
        logic       fs;
        logic       ls;
        logic [2:0] x;
        logic [2:0] y;
        logic       valid;
    } cyc_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    cyc_t cyc_q[$];
    pix_t pix_q[$];
    int   checks = 0;
    int   errors = 0;

    vga_timing_core #(
        .H_ACTIVE   (4),
        .H_FRONT    (1),
        .H_SYNC     (2),
        .H_BACK     (1),
        .V_ACTIVE   (3),
        .V_FRONT    (1),
        .V_SYNC     (1),
        .V_BACK     (1),
        .H_SYNC_POL (1'b1),
        .V_SYNC_POL (1'b0),
        .CLK_DIV    (2),
        .COLOR_W    (8)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .enable     (enable),
        .inRed      (inRed),
        .inGreen    (inGreen),
        .inBlue     (inBlue),
        .testMode   (testMode),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .pixelValid (pixelValid),
        .pixTick    (pixTick),
        .hSync      (hSync),
        .vSync      (vSync),
        .videoOn    (videoOn),
        .frameStart (frameStart),
        .lineStart  (lineStart),
        .outRed     (outRed),
        .outGreen   (outGreen),
        .outBlue    (outBlue)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle stage-0/strobe checks, plus a stage-1 check whenever
    // the DUT consumed a pixel tick at the preceding edge.
    initial begin
        cyc_t c;
        pix_t p;
        logic prev_tick;
        prev_tick = 1'b0;
        forever begin
            @(posedge clk);
            #5;
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("pixTick",    32'(pixTick),    32'(c.tick));
                check("frameStart", 32'(frameStart), 32'(c.fs));
                check("lineStart",  32'(lineStart),  32'(c.ls));
                check("pixelX",     32'(pixelX),     32'(c.x));
                check("pixelY",     32'(pixelY),     32'(c.y));
                check("pixelValid", 32'(pixelValid), 32'(c.valid));
                if (prev_tick) begin
                    if (pix_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pix_underflow: got tick with no expected pixel at %0t", $time);
                    end else begin
                        p = pix_q.pop_front();
                        check("hSync",    32'(hSync),    32'(p.hs));
                        check("vSync",    32'(vSync),    32'(p.vs));
                        check("videoOn",  32'(videoOn),  32'(p.von));
                        check("outRed",   32'(outRed),   32'(p.r));
                        check("outGreen", 32'(outGreen), 32'(p.g));
                        check("outBlue",  32'(outBlue),  32'(p.b));
                    end
                end
            end
            prev_tick = pixTick;
        end
    end

    // Driver: applies inputs at the falling edge and pushes the expected
    // response of the following rising edge.
    initial begin
        int         div_m, hx, vy, frame_m, low_cnt, low_edges, ncyc, idx;
        bit         done_en, tick_now, fs, ls;
        logic [7:0] er, eg, eb;
        cyc_t       ce;
        pix_t       pe;

        rstN     = 1'b0;
        enable   = 1'b1;
        testMode = 1'b0;
        inRed    = 8'h00;
        inGreen  = 8'h00;
        inBlue   = 8'h00;

        #50;
        check("rst_hSync",      32'(hSync),      32'(1'b0));
        check("rst_vSync",      32'(vSync),      32'(1'b1));
        check("rst_videoOn",    32'(videoOn),    32'(1'b0));
        check("rst_frameStart", 32'(frameStart), 32'(1'b0));
        check("rst_lineStart",  32'(lineStart),  32'(1'b0));
        check("rst_pixTick",    32'(pixTick),    32'(1'b0));
        check("rst_colour",     32'({outRed, outGreen, outBlue}), 32'(0));
        check("rst_pixelX",     32'(pixelX),     32'(0));
        check("rst_pixelY",     32'(pixelY),     32'(0));

        repeat (3) @(negedge clk);
        rstN = 1'b1;

        div_m = 0; hx = 0; vy = 0; frame_m = 0;
        low_cnt = 0; low_edges = 0; ncyc = 0; done_en = 1'b0;

        while (!(frame_m == 3 && hx == 2 && vy == 1) && ncyc < 2000) begin
            if (low_edges > 0) begin
                check("en_low_hSync",   32'(hSync),   32'(1'b0));
                check("en_low_vSync",   32'(vSync),   32'(1'b1));
                check("en_low_videoOn", 32'(videoOn), 32'(1'b0));
                check("en_low_colour",  32'({outRed, outGreen, outBlue}), 32'(0));
            end

            if (!done_en && frame_m == 1 && hx == 2 && vy == 1) begin
                enable  = 1'b0;
                low_cnt = 10;
                done_en = 1'b1;
            end else if (low_cnt > 0) begin
                low_cnt--;
                if (low_cnt == 0) enable = 1'b1;
            end

            testMode = (frame_m >= 2);
            if (frame_m == 0) begin
                inRed   = 8'hAA;
                inGreen = 8'h55;
                inBlue  = 8'h0F;
            end else begin
                inRed   = 8'(ncyc * 7 + 3);
                inGreen = 8'(ncyc * 13);
                inBlue  = ~inRed;
            end

            tick_now = enable && (div_m == 1);
            if (tick_now) begin
                pe.von = (hx < 4) && (vy < 3);
                pe.hs  = (hx >= 5) && (hx < 7);
                pe.vs  = (vy != 4);
                er = inRed;
                eg = inGreen;
                eb = inBlue;
`ifdef TEST_PATTERN_EN
                if (testMode) begin
                    idx = hx * 8 / 4;
                    er  = idx[2] ? 8'hFF : 8'h00;
                    eg  = idx[1] ? 8'hFF : 8'h00;
                    eb  = idx[0] ? 8'hFF : 8'h00;
                end
`else
                idx = 0;
`endif
                pe.r = pe.von ? er : 8'h00;
                pe.g = pe.von ? eg : 8'h00;
                pe.b = pe.von ? eb : 8'h00;
                pix_q.push_back(pe);
            end

            fs = tick_now && (hx == 0) && (vy == 0);
            ls = tick_now && (hx == 0) && (vy < 3);

            if (!enable) begin
                div_m = 0;
                hx    = 0;
                vy    = 0;
            end else begin
                if (tick_now) begin
                    if (hx == 7) begin
                        hx = 0;
                        if (vy == 5) begin
                            vy = 0;
                            frame_m++;
                        end else begin
                            vy++;
                        end
                    end else begin
                        hx++;
                    end
                end
                div_m = (div_m == 1) ? 0 : div_m + 1;
            end

            ce.tick  = enable && (div_m == 1);
            ce.fs    = fs;
            ce.ls    = ls;
            ce.x     = 3'(hx);
            ce.y     = 3'(vy);
            ce.valid = (hx < 4) && (vy < 3);
            cyc_q.push_back(ce);

            low_edges = enable ? 0 : low_edges + 1;
            ncyc++;
            @(negedge clk);
        end

        @(negedge clk);
        check("cyc_q_drained", 32'(cyc_q.size()), 32'(0));
        check("pix_q_drained", 32'(pix_q.size()), 32'(0));
        check("run_length",    32'(ncyc < 2000),  32'(1));

        rstN = 1'b0;
        #1;
        check("midrst_pixelX",  32'(pixelX),  32'(0));
        check("midrst_pixelY",  32'(pixelY),  32'(0));
        check("midrst_videoOn", 32'(videoOn), 32'(1'b0));
        check("midrst_pixTick", 32'(pixTick), 32'(1'b0));
        check("midrst_hSync",   32'(hSync),   32'(1'b0));
        check("midrst_vSync",   32'(vSync),   32'(1'b1));
        check("midrst_colour",  32'({outRed, outGreen, outBlue}), 32'(0));

        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_core.md
Name: vga_timing_core

Overview:
- Parametrised VGA timing generator and pixel output stage; successor to the fixed 640x480 vgaController.
- Generates hSync/vSync, pixel coordinates and active-video qualifier from the 50 MHz system clock via a pixel-tick divider.
- Registers colours supplied by an external pixel source (sprite/tile engine) and drives the DAC colour outputs blanked outside the active area.
- Adds programmable timing and sync polarity, an enable control, frame/line strobes and an optional test pattern.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of hSync
V_SYNC_POL, 0, active level of vSync
CLK_DIV, 2, clk cycles per pixel (>=1)
COLOR_W, 8, bits per colour channel

Ports:
clk  in  1  system clock (50 MHz)
rstN  in  1  asynchronous active-low reset
enable  in  1  timing run enable
inRed  in  COLOR_W  pixel source red for (pixelX,pixelY)
inGreen  in  COLOR_W  pixel source green
inBlue  in  COLOR_W  pixel source blue
testMode  in  1  select internal test pattern (see Optional Feature)
pixelX  out  X_W  current horizontal count
pixelY  out  Y_W  current vertical count
pixelValid  out  1  (pixelX,pixelY) inside active area
pixTick  out  1  one-clk strobe, pixel advance
hSync  out  1  horizontal sync
vSync  out  1  vertical sync
videoOn  out  1  registered active-video, aligned with colour outputs
frameStart  out  1  one-clk strobe, pixel (0,0) on outputs
lineStart  out  1  one-clk strobe, pixel (0,y) on outputs, y<V_ACTIVE
outRed  out  COLOR_W  DAC red
outGreen  out  COLOR_W  DAC green
outBlue  out  COLOR_W  DAC blue

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rstN), single clock domain.
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; X_W = clog2(H_TOTAL), Y_W = clog2(V_TOTAL).
- Reset: divider, hCount, vCount = 0; pixTick, videoOn, frameStart, lineStart = 0; colours = 0; hSync = ~H_SYNC_POL, vSync = ~V_SYNC_POL.
- Divider counts 0..CLK_DIV-1; pixTick = 1 in the cycle divider == CLK_DIV-1; CLK_DIV=1 -> pixTick every cycle.
- On pixTick: hCount++; at H_TOTAL-1 wraps to 0 and vCount++; vCount wraps to 0 at V_TOTAL-1 on the same tick hCount wraps.
- Stage 0 (combinational from counters): pixelX = hCount, pixelY = vCount, pixelValid = hCount<H_ACTIVE && vCount<V_ACTIVE. Source must present inRed/Green/Blue before the next pixTick.
- Stage 1 (registered on pixTick): outputs describe the stage-0 pixel; latency exactly one pixel period.
  - hSync active while hCount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vSync active while vCount in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
  - videoOn = pixelValid; colours = pixelValid ? in* : 0.
- frameStart / lineStart: high for the single clk cycle following the pixTick that registers hCount=0 with vCount=0 / vCount<V_ACTIVE.
- enable low: divider and counters synchronously cleared to 0; stage-1 forced to reset values; pixTick held 0. enable rising restarts at (0,0); first frameStart one pixel period later.
- Reset mid-frame: immediate return to reset values; no partial strobes.
- Parameters of zero porch/sync width are illegal (not checked in RTL).

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined: when testMode=1, in* ignored; active area shows 8 equal vertical colour bars, bar index = pixelX*8/H_ACTIVE, colour bits {R,G,B} = {idx[2],idx[1],idx[0]} each expanded to all-ones/all-zeros; timing unchanged.
- Undefined: testMode port present but ignored; colours always from in*.

Decomposition:
- Package vga_pkg: default 640x480@60 timing constants, sync polarity constants, colour-bar lookup constant.
- One sub-module, vga_axis_counter: divider-free counter with ACTIVE/FRONT/SYNC/BACK parameters, increment input, wrap strobe, active and sync outputs; instantiated twice (horizontal, vertical).

Test Plan:
- Reset: rstN=0 for 100 ns -> hSync=vSync=1, colours=0, videoOn=0, frameStart=0; release -> first pixTick at 40 ns, every 40 ns.
- Default timing: hSync low 96 ticks (3840 ns), period 800 ticks (32 us); vSync low 2 lines (64 us), period 525 lines (16.8 ms); frameStart every 16.8 ms.
- Colour path: inRed=AA, inGreen=55, inBlue=0F constant -> outputs equal these one pixel after pixelX=0,pixelY=0; during hCount=640..799 outputs 0, videoOn=0.
- Enable: drop enable at pixelX=300,pixelY=100 for 10 cycles -> syncs inactive, colours 0; re-enable -> counters restart at (0,0), frameStart one pixel period later.
- Small parameter set (CLK_DIV=1, H 4/1/2/1, V 3/1/1/1, H_SYNC_POL=1) -> line period 8 clk, hSync high clk 5-6 of line, frame period 48 clk.
- With TEST_PATTERN_EN, testMode=1 -> pixelX 0..79 gives 000000, 80..159 gives 0000FF, 560..639 gives FFFFFF.
